line_buffer: RTL and testbench



---
 rtl/video_pkg.sv | 29 ++
 rtl/line_ram.sv | 33 +++
 rtl/line_buffer.sv | 121 ++++++++++++
 tb/tb_line_buffer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types: RGB565 pixel, raster counter widths and colour field positions.
package video_pkg;

   typedef logic [15:0] pixel_t;

   localparam int HCOUNT_W  = 11;
   localparam int VCOUNT_W  = 10;
   localparam int NUM_LINES = 4;

   localparam int R_MSB = 15;
   localparam int R_LSB = 11;
   localparam int G_MSB = 10;
   localparam int G_LSB = 5;
   localparam int B_MSB = 4;
   localparam int B_LSB = 0;

   function automatic logic [4:0] rgb_red(input pixel_t p);
      return p[R_MSB:R_LSB];
   endfunction

   function automatic logic [5:0] rgb_green(input pixel_t p);
      return p[G_MSB:G_LSB];
   endfunction

   function automatic logic [4:0] rgb_blue(input pixel_t p);
      return p[B_MSB:B_LSB];
   endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line RAM, one clock, registered read data (one cycle address-to-data).
module line_ram
   import video_pkg::*;
#(
   parameter int DEPTH = 1280,
   parameter int AW    = 11
) (
   input  logic          clk_in,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  pixel_t        wr_data,
   input  logic [AW-1:0] rd_addr,
   output pixel_t        rd_data
);

   pixel_t mem [DEPTH];
   pixel_t rd_data_q;
   pixel_t rd_data_d;

   always_comb begin
      rd_data_d = mem[rd_addr];
   end

   always_ff @(posedge clk_in) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data_q <= rd_data_d;
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/line_buffer.sv
// Four rotating line RAMs turn a raster RGB565 stream into aligned 3-row columns, 2-cycle latency.
// Define LINE_BUFFER_EDGE_REPLICATE_EN to replicate the centre row over the out-of-frame row.
module line_buffer
   import video_pkg::*;
#(
   parameter int HRES = 1280,
   parameter int VRES = 720
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [15:0]         data_in,
   input  logic [HCOUNT_W-1:0] hcount_in,
   input  logic [VCOUNT_W-1:0] vcount_in,
   input  logic                data_valid_in,
   output logic [2:0][15:0]    data_out,
   output logic [HCOUNT_W-1:0] hcount_out,
   output logic [VCOUNT_W-1:0] vcount_out,
   output logic                data_valid_out
);

   localparam int RAM_AW = (HRES > 1) ? $clog2(HRES) : 1;
   localparam logic [HCOUNT_W-1:0] H_LAST = HCOUNT_W'(HRES - 1);
   localparam logic [VCOUNT_W-1:0] V_LAST = VCOUNT_W'(VRES - 1);
   localparam logic [VCOUNT_W-1:0] V_OFF  = VCOUNT_W'(VRES - 2);

   logic [1:0]          wr_sel_q, wr_sel_d, wr_eff;
   logic                frame_sync, line_end, wr_en;
   logic [RAM_AW-1:0]   ram_addr;
   pixel_t              rd_data [NUM_LINES];

   logic                valid_s1_q, valid_s1_d;
   logic [HCOUNT_W-1:0] hcount_s1_q, hcount_s1_d;
   logic [VCOUNT_W-1:0] vcount_s1_q, vcount_s1_d;
   logic [1:0]          sel_s1_q, sel_s1_d;

   logic [2:0][15:0]    data_out_q, data_out_d;
   logic [HCOUNT_W-1:0] hcount_out_q, hcount_out_d;
   logic [VCOUNT_W-1:0] vcount_out_q, vcount_out_d;
   logic                valid_out_q, valid_out_d;
   logic [1:0]          top_idx, mid_idx, bot_idx;

   // Frame sync overrides the rotation so the first line of a frame always lands in RAM 0.
   always_comb begin
      frame_sync  = data_valid_in && (hcount_in == '0) && (vcount_in == '0);
      line_end    = data_valid_in && (hcount_in == H_LAST);
      wr_eff      = frame_sync ? 2'd0 : wr_sel_q;
      wr_en       = data_valid_in && !rst_in;
      wr_sel_d    = line_end ? 2'(wr_eff + 2'd1) : wr_eff;
      ram_addr    = hcount_in[RAM_AW-1:0];
      valid_s1_d  = data_valid_in;
      hcount_s1_d = hcount_in;
      vcount_s1_d = (vcount_in >= VCOUNT_W'(2)) ? VCOUNT_W'(vcount_in - VCOUNT_W'(2))
                                                : VCOUNT_W'(vcount_in + V_OFF);
      sel_s1_d    = wr_eff;
   end

   for (genvar i = 0; i < NUM_LINES; i++) begin : g_ram
      line_ram #(
         .DEPTH (HRES),
         .AW    (RAM_AW)
      ) u_line_ram (
         .clk_in  (clk_in),
         .wr_en   (wr_en && (wr_eff == 2'(i))),
         .wr_addr (ram_addr),
         .wr_data (data_in),
         .rd_addr (ram_addr),
         .rd_data (rd_data[i])
      );
   end

   // Row mapping comes from the write select captured alongside the read address.
   always_comb begin
      top_idx       = 2'(sel_s1_q + 2'd1);
      mid_idx       = 2'(sel_s1_q + 2'd2);
      bot_idx       = 2'(sel_s1_q + 2'd3);
      data_out_d[0] = rd_data[top_idx];
      data_out_d[1] = rd_data[mid_idx];
      data_out_d[2] = rd_data[bot_idx];
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
      if (vcount_s1_q == '0) begin
         data_out_d[0] = data_out_d[1];
      end
      if (vcount_s1_q == V_LAST) begin
         data_out_d[2] = data_out_d[1];
      end
`endif
      hcount_out_d  = hcount_s1_q;
      vcount_out_d  = vcount_s1_q;
      valid_out_d   = valid_s1_q;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_sel_q     <= '0;
         valid_s1_q   <= 1'b0;
         hcount_s1_q  <= '0;
         vcount_s1_q  <= '0;
         sel_s1_q     <= '0;
         data_out_q   <= '0;
         hcount_out_q <= '0;
         vcount_out_q <= '0;
         valid_out_q  <= 1'b0;
      end else begin
         wr_sel_q     <= wr_sel_d;
         valid_s1_q   <= valid_s1_d;
         hcount_s1_q  <= hcount_s1_d;
         vcount_s1_q  <= vcount_s1_d;
         sel_s1_q     <= sel_s1_d;
         data_out_q   <= data_out_d;
         hcount_out_q <= hcount_out_d;
         vcount_out_q <= vcount_out_d;
         valid_out_q  <= valid_out_d;
      end
   end

   assign data_out       = data_out_q;
   assign hcount_out     = hcount_out_q;
   assign vcount_out     = vcount_out_q;
   assign data_valid_out = valid_out_q;

endmodule

// File: tb/tb_line_buffer.sv
// Directed bench for line_buffer at HRES=4, VRES=4; pixel value = {vcount[3:0],hcount[3:0]}.
module tb_line_buffer;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic [15:0]      data_in = '0;
   logic [10:0]      hcount_in = '0;
   logic [9:0]       vcount_in = '0;
   logic             data_valid_in = 1'b0;
   logic [2:0][15:0] data_out;
   logic [10:0]      hcount_out;
   logic [9:0]       vcount_out;
   logic             data_valid_out;

   int total = 0;
   int bad   = 0;

   // Inputs of the previous drive() call: that is what the outputs show after the current one.
   logic cur_valid = 1'b0;
   int   cur_h = 0;
   int   cur_v = 0;
   logic exp_valid = 1'b0;
   int   exp_h = 0;
   int   exp_v = 0;

   // centre-row vcount_out for each input row (hand table, VRES=4)
   int vc_tab [4] = '{2, 3, 0, 1};

   line_buffer #(
      .HRES (4),
      .VRES (4)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .data_in        (data_in),
      .hcount_in      (hcount_in),
      .vcount_in      (vcount_in),
      .data_valid_in  (data_valid_in),
      .data_out       (data_out),
      .hcount_out     (hcount_out),
      .vcount_out     (vcount_out),
      .data_valid_out (data_valid_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0] px(input int v, input int h);
      return 16'(((v % 16) * 16) + (h % 16));
   endfunction

   // Expected row r (0 top, 1 centre, 2 bottom) for input row v: line v-3+r mod 4.
   function automatic logic [15:0] exp_row(input int v, input int h, input int r);
      int line;
      line = (v + 1 + r) % 4;
`ifdef LINE_BUFFER_EDGE_REPLICATE_EN
      if (v == 2 && r == 0) line = 0;
      if (v == 1 && r == 2) line = 3;
`endif
      return px(line, h);
   endfunction

   task automatic drive(input logic vld, input int v, input int h, input logic [15:0] d);
      exp_valid     = cur_valid;
      exp_h         = cur_h;
      exp_v         = cur_v;
      data_valid_in = vld;
      vcount_in     = 10'(v);
      hcount_in     = 11'(h);
      data_in       = d;
      cur_valid     = vld;
      cur_v         = v;
      cur_h         = h;
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 0, 3, 16'hBEEF);
         total++;
         if (data_valid_out !== 1'b0 || hcount_out !== 11'd0 || vcount_out !== 10'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got dv=%b h=%0d v=%0d want 0/0/0", data_valid_out, hcount_out, vcount_out);
         end
         total++;
         if (data_out !== 48'h0) begin
            bad++;
            $display("FAIL reset_data: got %h want 0", data_out);
         end
      end
      rst_in = 1'b0;
      drive(1'b1, 0, 0, px(0, 0));
      total++;
      if (data_valid_out !== 1'b0) begin
         bad++;
         $display("FAIL reset_release_dv0: got %b want 0", data_valid_out);
      end
      drive(1'b1, 0, 1, px(0, 1));
      total++;
      if (data_valid_out !== 1'b1 || hcount_out !== 11'd0 || vcount_out !== 10'd2) begin
         bad++;
         $display("FAIL reset_first_pixel: got dv=%b h=%0d v=%0d want 1/0/2", data_valid_out, hcount_out, vcount_out);
      end
   endtask

   // Rest of frame 1; rows are only known once lines 0..2 have been written.
   task automatic test_stream();
      for (int v = 0; v < 4; v++) begin
         for (int h = (v == 0) ? 2 : 0; h < 4; h++) begin
            drive(1'b1, v, h, px(v, h));
            if (exp_valid) begin
               total++;
               if (data_valid_out !== 1'b1 || hcount_out !== 11'(exp_h) || vcount_out !== 10'(vc_tab[exp_v])) begin
                  bad++;
                  $display("FAIL stream_ctrl v%0d h%0d: got dv=%b h=%0d v=%0d want 1/%0d/%0d",
                           exp_v, exp_h, data_valid_out, hcount_out, vcount_out, exp_h, vc_tab[exp_v]);
               end
               if (exp_v == 3) begin
                  for (int r = 0; r < 3; r++) begin
                     total++;
                     if (data_out[r] !== exp_row(exp_v, exp_h, r)) begin
                        bad++;
                        $display("FAIL stream_row%0d h%0d: got %h want %h", r, exp_h, data_out[r], exp_row(exp_v, exp_h, r));
                     end
                  end
               end
            end
         end
      end
   endtask

   // Frame 2 lines 0 and 1: centre row index wraps back to VRES-2 / VRES-1.
   task automatic test_row_wrap();
      for (int v = 0; v < 2; v++) begin
         for (int h = 0; h < 4; h++) begin
            drive(1'b1, v, h, px(v, h));
            total++;
            if (data_valid_out !== 1'b1 || hcount_out !== 11'(exp_h) || vcount_out !== 10'(vc_tab[exp_v])) begin
               bad++;
               $display("FAIL wrap_ctrl v%0d h%0d: got dv=%b h=%0d v=%0d want 1/%0d/%0d",
                        exp_v, exp_h, data_valid_out, hcount_out, vcount_out, exp_h, vc_tab[exp_v]);
            end
            for (int r = 0; r < 3; r++) begin
               total++;
               if (data_out[r] !== exp_row(exp_v, exp_h, r)) begin
                  bad++;
                  $display("FAIL wrap_row%0d v%0d h%0d: got %h want %h", r, exp_v, exp_h, data_out[r], exp_row(exp_v, exp_h, r));
               end
            end
         end
      end
   endtask

   // Frame 2 line 2 with valid dropped every other cycle; garbage on invalid cycles must not land.
   task automatic test_valid_gaps();
      int          hs [5];
      logic [4:0]  vs;
      hs = '{0, 1, 2, 1, 3};
      vs = 5'b10101;
      for (int i = 0; i < 5; i++) begin
         drive(vs[4-i], 2, hs[i], vs[4-i] ? px(2, hs[i]) : 16'hDEAD);
         total++;
         if (data_valid_out !== exp_valid) begin
            bad++;
            $display("FAIL gaps_dv step%0d: got %b want %b", i, data_valid_out, exp_valid);
         end
         if (exp_valid) begin
            total++;
            if (hcount_out !== 11'(exp_h) || vcount_out !== 10'(vc_tab[exp_v])) begin
               bad++;
               $display("FAIL gaps_ctrl step%0d: got h=%0d v=%0d want %0d/%0d", i, hcount_out, vcount_out, exp_h, vc_tab[exp_v]);
            end
            for (int r = 0; r < 3; r++) begin
               total++;
               if (data_out[r] !== exp_row(exp_v, exp_h, r)) begin
                  bad++;
                  $display("FAIL gaps_row%0d step%0d: got %h want %h", r, i, data_out[r], exp_row(exp_v, exp_h, r));
               end
            end
         end
      end
   endtask

   // Frame 2 line 3 streamed back to back, then flushed; bottom row is the gapped line.
   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         if (i < 4) drive(1'b1, 3, i, px(3, i));
         else       drive(1'b0, 0, 0, 16'h0);
         total++;
         if (data_valid_out !== exp_valid) begin
            bad++;
            $display("FAIL b2b_dv step%0d: got %b want %b", i, data_valid_out, exp_valid);
         end
         if (exp_valid) begin
            total++;
            if (hcount_out !== 11'(exp_h) || vcount_out !== 10'(vc_tab[exp_v])) begin
               bad++;
               $display("FAIL b2b_ctrl step%0d: got h=%0d v=%0d want %0d/%0d", i, hcount_out, vcount_out, exp_h, vc_tab[exp_v]);
            end
            for (int r = 0; r < 3; r++) begin
               total++;
               if (data_out[r] !== exp_row(exp_v, exp_h, r)) begin
                  bad++;
                  $display("FAIL b2b_row%0d step%0d: got %h want %h", r, i, data_out[r], exp_row(exp_v, exp_h, r));
               end
            end
         end
      end
   endtask

   // Abandon frame 3 at v=2,h=1, then restart at (0,0) and stream line 0.
   task automatic test_midline_reset();
      for (int v = 0; v < 3; v++) begin
         for (int h = 0; h < ((v == 2) ? 1 : 4); h++) begin
            drive(1'b1, v, h, px(v, h));
         end
      end
      rst_in = 1'b1;
      drive(1'b1, 2, 1, px(2, 1));
      total++;
      if (data_valid_out !== 1'b0 || hcount_out !== 11'd0 || vcount_out !== 10'd0 || data_out !== 48'h0) begin
         bad++;
         $display("FAIL midreset_zero: got dv=%b h=%0d v=%0d d=%h want all 0", data_valid_out, hcount_out, vcount_out, data_out);
      end
      rst_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 0, 0, 16'h0);
         total++;
         if (data_valid_out !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle%0d: got dv=%b want 0", i, data_valid_out);
         end
      end
      for (int h = 0; h < 4; h++) begin
         drive(1'b1, 0, h, px(0, h));
         if (exp_valid) begin
            total++;
            if ($isunknown({data_out, hcount_out, vcount_out}) || hcount_out !== 11'(exp_h) ||
                vcount_out !== 10'(vc_tab[exp_v])) begin
               bad++;
               $display("FAIL midreset_ctrl h%0d: got h=%0d v=%0d d=%h want %0d/%0d", exp_h, hcount_out, vcount_out, data_out, exp_h, vc_tab[exp_v]);
            end
            for (int r = 0; r < 3; r++) begin
               total++;
               if (data_out[r] !== exp_row(exp_v, exp_h, r)) begin
                  bad++;
                  $display("FAIL midreset_row%0d h%0d: got %h want %h", r, exp_h, data_out[r], exp_row(exp_v, exp_h, r));
               end
            end
         end
      end
   endtask

   // Lines 1..3 of the restarted frame: centre rows 3 and 0 are the replicate boundaries.
   task automatic test_edge_replicate();
      for (int i = 0; i < 13; i++) begin
         if (i < 12) drive(1'b1, 1 + i / 4, i % 4, px(1 + i / 4, i % 4));
         else        drive(1'b0, 0, 0, 16'h0);
         total++;
         if (data_valid_out !== 1'b1 || hcount_out !== 11'(exp_h) || vcount_out !== 10'(vc_tab[exp_v])) begin
            bad++;
            $display("FAIL edge_ctrl v%0d h%0d: got dv=%b h=%0d v=%0d want 1/%0d/%0d",
                     exp_v, exp_h, data_valid_out, hcount_out, vcount_out, exp_h, vc_tab[exp_v]);
         end
         for (int r = 0; r < 3; r++) begin
            total++;
            if (data_out[r] !== exp_row(exp_v, exp_h, r)) begin
               bad++;
               $display("FAIL edge_row%0d v%0d h%0d: got %h want %h", r, exp_v, exp_h, data_out[r], exp_row(exp_v, exp_h, r));
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_row_wrap();
      test_valid_gaps();
      test_back_to_back();
      test_midline_reset();
      test_edge_replicate();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
